// File: rtl/dispatch_stage_n_pkg.sv
// Shared types, queue indices, MIPS encodings and the instruction classifier
// used by the dispatch stage and its decoder.
package dispatch_pkg;

    localparam int Q_INT = 0;
    localparam int Q_LS  = 1;
    localparam int Q_MUL = 2;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LS,
        CLS_MUL,
        CLS_BR,
        CLS_J,
        CLS_NOP
    } cls_e;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_HOLD,
        S_REDIRECT
    } state_e;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_J       = 6'h02;
    localparam logic [5:0] OPC_JAL     = 6'h03;
    localparam logic [5:0] OPC_BEQ     = 6'h04;
    localparam logic [5:0] OPC_BNE     = 6'h05;
    localparam logic [5:0] OPC_ADDI    = 6'h08;
    localparam logic [5:0] OPC_ADDIU   = 6'h09;
    localparam logic [5:0] OPC_SLTI    = 6'h0A;
    localparam logic [5:0] OPC_SLTIU   = 6'h0B;
    localparam logic [5:0] OPC_ANDI    = 6'h0C;
    localparam logic [5:0] OPC_ORI     = 6'h0D;
    localparam logic [5:0] OPC_XORI    = 6'h0E;
    localparam logic [5:0] OPC_LUI     = 6'h0F;
    localparam logic [5:0] OPC_LW      = 6'h23;
    localparam logic [5:0] OPC_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // Opcode meaning is per target queue; the multiply queue reuses codes 0/1.
    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_AND   = 4'h2;
    localparam logic [3:0] ALU_OR    = 4'h3;
    localparam logic [3:0] ALU_XOR   = 4'h4;
    localparam logic [3:0] ALU_NOR   = 4'h5;
    localparam logic [3:0] ALU_SLT   = 4'h6;
    localparam logic [3:0] ALU_SLTU  = 4'h7;
    localparam logic [3:0] ALU_SLL   = 4'h8;
    localparam logic [3:0] ALU_SRL   = 4'h9;
    localparam logic [3:0] ALU_SRA   = 4'hA;
    localparam logic [3:0] ALU_LUI   = 4'hB;
    localparam logic [3:0] LS_LW     = 4'hC;
    localparam logic [3:0] LS_SW     = 4'hD;
    localparam logic [3:0] BR_BEQ    = 4'hE;
    localparam logic [3:0] BR_BNE    = 4'hF;
    localparam logic [3:0] MUL_MULT  = 4'h0;
    localparam logic [3:0] MUL_MULTU = 4'h1;

    typedef struct packed {
        cls_e       cls;
        logic [3:0] opcode;
        logic       has_dest;
    } decode_t;

    // Unrecognised encodings classify as NOP so they are popped and dropped.
    function automatic decode_t classify(input logic [31:0] instr);
        decode_t d;
        d.cls      = CLS_NOP;
        d.opcode   = 4'h0;
        d.has_dest = 1'b0;
        if (instr != 32'h0) begin
            case (instr[31:26])
                OPC_SPECIAL: begin
                    d.cls      = CLS_R;
                    d.has_dest = 1'b1;
                    case (instr[5:0])
                        FN_ADD, FN_ADDU: d.opcode = ALU_ADD;
                        FN_SUB, FN_SUBU: d.opcode = ALU_SUB;
                        FN_AND:          d.opcode = ALU_AND;
                        FN_OR:           d.opcode = ALU_OR;
                        FN_XOR:          d.opcode = ALU_XOR;
                        FN_NOR:          d.opcode = ALU_NOR;
                        FN_SLT:          d.opcode = ALU_SLT;
                        FN_SLTU:         d.opcode = ALU_SLTU;
                        FN_SLL:          d.opcode = ALU_SLL;
                        FN_SRL:          d.opcode = ALU_SRL;
                        FN_SRA:          d.opcode = ALU_SRA;
                        FN_MULT: begin
                            d.cls    = CLS_MUL;
                            d.opcode = MUL_MULT;
                        end
                        FN_MULTU: begin
                            d.cls    = CLS_MUL;
                            d.opcode = MUL_MULTU;
                        end
                        default: begin
                            d.cls      = CLS_NOP;
                            d.has_dest = 1'b0;
                        end
                    endcase
                end
                OPC_ADDI, OPC_ADDIU: begin d.cls = CLS_I; d.opcode = ALU_ADD;  d.has_dest = 1'b1; end
                OPC_SLTI:            begin d.cls = CLS_I; d.opcode = ALU_SLT;  d.has_dest = 1'b1; end
                OPC_SLTIU:           begin d.cls = CLS_I; d.opcode = ALU_SLTU; d.has_dest = 1'b1; end
                OPC_ANDI:            begin d.cls = CLS_I; d.opcode = ALU_AND;  d.has_dest = 1'b1; end
                OPC_ORI:             begin d.cls = CLS_I; d.opcode = ALU_OR;   d.has_dest = 1'b1; end
                OPC_XORI:            begin d.cls = CLS_I; d.opcode = ALU_XOR;  d.has_dest = 1'b1; end
                OPC_LUI:             begin d.cls = CLS_I; d.opcode = ALU_LUI;  d.has_dest = 1'b1; end
                OPC_LW:              begin d.cls = CLS_LS; d.opcode = LS_LW;   d.has_dest = 1'b1; end
                OPC_SW:              begin d.cls = CLS_LS; d.opcode = LS_SW; end
                OPC_BEQ:             begin d.cls = CLS_BR; d.opcode = BR_BEQ; end
                OPC_BNE:             begin d.cls = CLS_BR; d.opcode = BR_BNE; end
                OPC_J, OPC_JAL:      d.cls = CLS_J;
                default:             d.cls = CLS_NOP;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/dispatch_stage_n_if.sv
// Bundle of every dispatch-stage connection except clock/reset; the master
// modport is the dispatch stage, the slave modport its surroundings.
interface dispatch_stage_n_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int NUM_Q  = 3,
    parameter int REG_AW = 5
);
    logic [DATA_W-1:0] ifetch_pc_4;
    logic [31:0]       ifetch_instruction;
    logic              ifetch_empty;
    logic              Dispatch_ren;
    logic              Dispatch_jmp;
    logic [DATA_W-1:0] Dispatch_jmp_addr;

    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              rs_valid;
    logic              rt_valid;
    logic [TAG_W-1:0]  rs_tag;
    logic [TAG_W-1:0]  rt_tag;

    logic              tag_avail;
    logic [TAG_W-1:0]  tag_in;
    logic              tag_ren;
    logic              rob_ready;
    logic              rob_alloc;

    logic [NUM_Q-1:0]  q_full;
    logic [NUM_Q-1:0]  dispatch_en;
    logic [DATA_W-1:0] dispatch_rs_data;
    logic [DATA_W-1:0] dispatch_rt_data;
    logic              dispatch_rs_valid;
    logic              dispatch_rt_valid;
    logic [TAG_W-1:0]  dispatch_rs_tag;
    logic [TAG_W-1:0]  dispatch_rt_tag;
    logic [TAG_W-1:0]  dispatch_rd_tag;
    logic [3:0]        dispatch_opcode;
    logic [4:0]        dispatch_shfamt;
    logic [15:0]       dispatch_imm;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              retire_flush;
    logic [DATA_W-1:0] retire_target;

    modport master (
        input  ifetch_pc_4, ifetch_instruction, ifetch_empty,
        output Dispatch_ren, Dispatch_jmp, Dispatch_jmp_addr,
        output rs_addr, rt_addr,
        input  rs_data, rt_data, rs_valid, rt_valid, rs_tag, rt_tag,
        input  tag_avail, tag_in, rob_ready,
        output tag_ren, rob_alloc,
        input  q_full,
        output dispatch_en, dispatch_rs_data, dispatch_rt_data,
        output dispatch_rs_valid, dispatch_rt_valid,
        output dispatch_rs_tag, dispatch_rt_tag, dispatch_rd_tag,
        output dispatch_opcode, dispatch_shfamt, dispatch_imm,
        input  cdb_valid, cdb_tag, cdb_data, retire_flush, retire_target
    );

    modport slave (
        output ifetch_pc_4, ifetch_instruction, ifetch_empty,
        input  Dispatch_ren, Dispatch_jmp, Dispatch_jmp_addr,
        input  rs_addr, rt_addr,
        output rs_data, rt_data, rs_valid, rt_valid, rs_tag, rt_tag,
        output tag_avail, tag_in, rob_ready,
        input  tag_ren, rob_alloc,
        output q_full,
        input  dispatch_en, dispatch_rs_data, dispatch_rt_data,
        input  dispatch_rs_valid, dispatch_rt_valid,
        input  dispatch_rs_tag, dispatch_rt_tag, dispatch_rd_tag,
        input  dispatch_opcode, dispatch_shfamt, dispatch_imm,
        output cdb_valid, cdb_tag, cdb_data, retire_flush, retire_target
    );

endinterface

// File: rtl/dispatch_stage_n_decode.sv
// Combinational field decode of the IFQ head: class, queue opcode, shift
// amount, immediate, destination flag and target issue-queue index.
module dispatch_decode
    import dispatch_pkg::*;
#(
    parameter int QW = 2
) (
    input  logic [31:0]   instr,
    output cls_e          cls,
    output logic [3:0]    opcode,
    output logic [4:0]    shfamt,
    output logic [15:0]   imm,
    output logic          has_dest,
    output logic [QW-1:0] q_idx
);

    decode_t dec;

    always_comb begin
        dec      = classify(instr);
        cls      = dec.cls;
        opcode   = dec.opcode;
        has_dest = dec.has_dest;
        shfamt   = instr[10:6];
        imm      = instr[15:0];
        case (dec.cls)
            CLS_LS:  q_idx = QW'(Q_LS);
            CLS_MUL: q_idx = QW'(Q_MUL);
            default: q_idx = QW'(Q_INT);
        endcase
    end

endmodule

// File: rtl/dispatch_stage_n.sv
// One-entry dispatch hold stage feeding NUM_Q issue queues, with local J/JAL
// redirect and retire flush. Define DISPATCH_CDB_BYPASS_EN to snoop the CDB.
module dispatch_stage_n
    import dispatch_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int NUM_Q  = 3,
    parameter int REG_AW = 5
) (
    input logic               clock,
    input logic               reset,
    dispatch_stage_n_if.master bus
);

    localparam int QW = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;

    state_e state_q, state_d;

    cls_e              d_cls;
    logic [3:0]        d_opcode;
    logic [4:0]        d_shfamt;
    logic [15:0]       d_imm;
    logic              d_dest;
    logic [QW-1:0]     d_q;

    cls_e              h_cls;
    logic [3:0]        h_opcode;
    logic [4:0]        h_shfamt;
    logic [15:0]       h_imm;
    logic              h_dest;
    logic [QW-1:0]     h_q;
    logic [DATA_W-1:0] h_pc4;
    logic [25:0]       h_jidx;
    logic [DATA_W-1:0] rs_data_q, rt_data_q;
    logic              rs_valid_q, rt_valid_q;
    logic [TAG_W-1:0]  rs_tag_q, rt_tag_q;

    logic              held_queue, drain_ok, accept;
    logic              rs_hit_hold, rt_hit_hold, rs_hit_acc, rt_hit_acc;
    logic [NUM_Q-1:0]  held_onehot;
    logic [DATA_W-1:0] jump_target;

    logic              ren, jmp, tag_ren, rob_alloc;
    logic [DATA_W-1:0] jmp_addr;
    logic [NUM_Q-1:0]  en;
    logic [TAG_W-1:0]  rd_tag;

    dispatch_decode #(.QW(QW)) u_decode (
        .instr    (bus.ifetch_instruction),
        .cls      (d_cls),
        .opcode   (d_opcode),
        .shfamt   (d_shfamt),
        .imm      (d_imm),
        .has_dest (d_dest),
        .q_idx    (d_q)
    );

    assign bus.rs_addr = REG_AW'(bus.ifetch_instruction[25:21]);
    assign bus.rt_addr = REG_AW'(bus.ifetch_instruction[20:16]);

    // A held jump never drains to a queue; it only redirects fetch.
    assign held_queue = (state_q == S_HOLD) && (h_cls != CLS_J);
    assign drain_ok   = held_queue && !bus.q_full[h_q] && bus.rob_ready
                        && (bus.tag_avail || !h_dest);
    assign accept     = !bus.ifetch_empty && !bus.retire_flush
                        && ((state_q == S_EMPTY) || drain_ok);

`ifdef DISPATCH_CDB_BYPASS_EN
    assign rs_hit_hold = (state_q == S_HOLD) && !rs_valid_q && bus.cdb_valid && (bus.cdb_tag == rs_tag_q);
    assign rt_hit_hold = (state_q == S_HOLD) && !rt_valid_q && bus.cdb_valid && (bus.cdb_tag == rt_tag_q);
    assign rs_hit_acc  = !bus.rs_valid && bus.cdb_valid && (bus.cdb_tag == bus.rs_tag);
    assign rt_hit_acc  = !bus.rt_valid && bus.cdb_valid && (bus.cdb_tag == bus.rt_tag);
`else
    assign rs_hit_hold = 1'b0;
    assign rt_hit_hold = 1'b0;
    assign rs_hit_acc  = 1'b0;
    assign rt_hit_acc  = 1'b0;
`endif

    always_comb begin
        held_onehot = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            held_onehot[i] = (h_q == QW'(i));
        end
        jump_target       = h_pc4;
        jump_target[27:0] = {h_jidx, 2'b00};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Retire flush overrides everything decided by the state case above it.
    always_comb begin
        state_d   = state_q;
        ren       = accept;
        jmp       = 1'b0;
        jmp_addr  = '0;
        en        = '0;
        tag_ren   = 1'b0;
        rob_alloc = 1'b0;
        rd_tag    = '0;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d = (d_cls == CLS_NOP) ? S_EMPTY : S_HOLD;
                end
            end
            S_HOLD: begin
                if (h_cls == CLS_J) begin
                    jmp      = 1'b1;
                    jmp_addr = jump_target;
                    state_d  = S_REDIRECT;
                end else if (drain_ok) begin
                    en        = held_onehot;
                    rob_alloc = 1'b1;
                    tag_ren   = h_dest;
                    rd_tag    = bus.tag_in;
                    if (accept && (d_cls != CLS_NOP)) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
            end
            S_REDIRECT: state_d = S_EMPTY;
            default:    state_d = S_EMPTY;
        endcase
        if (bus.retire_flush) begin
            jmp       = 1'b1;
            jmp_addr  = bus.retire_target;
            en        = '0;
            tag_ren   = 1'b0;
            rob_alloc = 1'b0;
            rd_tag    = '0;
            state_d   = S_REDIRECT;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_cls      <= CLS_R;
            h_opcode   <= '0;
            h_shfamt   <= '0;
            h_imm      <= '0;
            h_dest     <= 1'b0;
            h_q        <= '0;
            h_pc4      <= '0;
            h_jidx     <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            rs_valid_q <= 1'b0;
            rt_valid_q <= 1'b0;
            rs_tag_q   <= '0;
            rt_tag_q   <= '0;
        end else if (accept) begin
            h_cls      <= d_cls;
            h_opcode   <= d_opcode;
            h_shfamt   <= d_shfamt;
            h_imm      <= d_imm;
            h_dest     <= d_dest;
            h_q        <= d_q;
            h_pc4      <= bus.ifetch_pc_4;
            h_jidx     <= bus.ifetch_instruction[25:0];
            rs_valid_q <= bus.rs_valid | rs_hit_acc;
            rt_valid_q <= bus.rt_valid | rt_hit_acc;
            rs_data_q  <= bus.rs_valid ? bus.rs_data : (rs_hit_acc ? bus.cdb_data : '0);
            rt_data_q  <= bus.rt_valid ? bus.rt_data : (rt_hit_acc ? bus.cdb_data : '0);
            rs_tag_q   <= bus.rs_tag;
            rt_tag_q   <= bus.rt_tag;
        end else begin
            if (rs_hit_hold) begin
                rs_valid_q <= 1'b1;
                rs_data_q  <= bus.cdb_data;
            end
            if (rt_hit_hold) begin
                rt_valid_q <= 1'b1;
                rt_data_q  <= bus.cdb_data;
            end
        end
    end

    assign bus.Dispatch_ren      = ren;
    assign bus.Dispatch_jmp      = jmp;
    assign bus.Dispatch_jmp_addr = jmp_addr;
    assign bus.tag_ren           = tag_ren;
    assign bus.rob_alloc         = rob_alloc;
    assign bus.dispatch_en       = en;
    assign bus.dispatch_rd_tag   = rd_tag;
    // A same-cycle CDB hit is forwarded so a draining operand is never stale.
    assign bus.dispatch_rs_data  = rs_hit_hold ? bus.cdb_data : rs_data_q;
    assign bus.dispatch_rt_data  = rt_hit_hold ? bus.cdb_data : rt_data_q;
    assign bus.dispatch_rs_valid = rs_valid_q | rs_hit_hold;
    assign bus.dispatch_rt_valid = rt_valid_q | rt_hit_hold;
    assign bus.dispatch_rs_tag   = rs_tag_q;
    assign bus.dispatch_rt_tag   = rt_tag_q;
    assign bus.dispatch_opcode   = h_opcode;
    assign bus.dispatch_shfamt   = h_shfamt;
    assign bus.dispatch_imm      = h_imm;

endmodule
